// File: rtl/color_config_arbiter.sv
// -----------------------------------------------------------------------------
// color_config_arbiter
//
// Shares the single colour-register write port between two requesters:
//   requester 0 : UART configuration path
//   requester 1 : VGA debug pattern sequencer
// Round-robin arbitration, one write in flight at a time. Writes can be held
// until the vertical blanking window so quadrant colour changes never tear.
// A write that sees no C_Rdy within TIMEOUT_CYCLES cycles is dropped and
// reported with a one-cycle Timeout_Err pulse.
//
// Ports
//   Clk, Rst                        clock / synchronous active-low reset
//   Req0_Valid/Addr/Data, Req0_Rdy  UART requester handshake
//   Req1_Valid/Addr/Data, Req1_Rdy  debug requester handshake
//   VSync                           write-window qualifier
//   C_Addr/C_Data/C_Valid, C_Rdy    colour register write port
//   Grant_Id                        requester owning current/last write
//   Busy                            high whenever a write is pending
//   Timeout_Err                     one-cycle pulse on an aborted write
// -----------------------------------------------------------------------------
module color_config_arbiter #(
    parameter int C_ADDR_WIDTH   = 2,
    parameter int C_DATA_WIDTH   = 8,
    parameter int FRAME_SYNC     = 1,
    parameter int VSYNC_POL      = 1,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic                    Req0_Valid,
    input  logic [C_ADDR_WIDTH-1:0] Req0_Addr,
    input  logic [C_DATA_WIDTH-1:0] Req0_Data,
    output logic                    Req0_Rdy,
    input  logic                    Req1_Valid,
    input  logic [C_ADDR_WIDTH-1:0] Req1_Addr,
    input  logic [C_DATA_WIDTH-1:0] Req1_Data,
    output logic                    Req1_Rdy,
    input  logic                    VSync,
    output logic [C_ADDR_WIDTH-1:0] C_Addr,
    output logic [C_DATA_WIDTH-1:0] C_Data,
    output logic                    C_Valid,
    input  logic                    C_Rdy,
    output logic                    Grant_Id,
    output logic                    Busy,
    output logic                    Timeout_Err
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] COUNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_SYNC = 2'd1,
        ST_ISSUE     = 2'd2
    } state_t;

    state_t                  state_reg;
    logic [CNT_W-1:0]        count_reg;
    logic                    last_grant_reg;
    logic                    grant_id_reg;
    logic [C_ADDR_WIDTH-1:0] c_addr_reg;
    logic [C_DATA_WIDTH-1:0] c_data_reg;
    logic                    c_valid_reg;
    logic                    timeout_err_reg;

    // Requesters gathered into vectors so the handshake logic is uniform.
    logic [1:0]                    req_valid;
    logic [1:0]                    req_rdy;
    logic [1:0][C_ADDR_WIDTH-1:0]  req_addr;
    logic [1:0][C_DATA_WIDTH-1:0]  req_data;

    assign req_valid = {Req1_Valid, Req0_Valid};
    assign req_addr  = {Req1_Addr, Req0_Addr};
    assign req_data  = {Req1_Data, Req0_Data};

    logic sel;
    logic transfer;
    logic window_open;

    // On a tie the requester not granted last wins; otherwise the lone valid
    // one is selected (sel is a don't-care when neither is valid).
    always_comb begin
        sel = 1'b0;
        if (req_valid[0] && req_valid[1]) begin
            sel = ~last_grant_reg;
        end else begin
            sel = req_valid[1];
        end
    end

    // Only the selected requester ever sees Rdy, so the two can never be high
    // together.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rdy
            assign req_rdy[gi] = (state_reg == ST_IDLE) && req_valid[gi] &&
                                 (sel == 1'(gi));
        end
    endgenerate

    assign Req0_Rdy = req_rdy[0];
    assign Req1_Rdy = req_rdy[1];
    assign transfer = |req_rdy;

    assign window_open = (FRAME_SYNC == 0) || (VSync == 1'(VSYNC_POL));

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_reg       <= ST_IDLE;
            count_reg       <= '0;
            last_grant_reg  <= 1'b1;   // makes requester 0 win the first tie
            grant_id_reg    <= 1'b0;
            c_addr_reg      <= '0;
            c_data_reg      <= '0;
            c_valid_reg     <= 1'b0;
            timeout_err_reg <= 1'b0;
        end else begin
            timeout_err_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (transfer) begin
                        c_addr_reg   <= req_addr[sel];
                        c_data_reg   <= req_data[sel];
                        grant_id_reg <= sel;
                        state_reg    <= ST_WAIT_SYNC;
                    end
                end
                ST_WAIT_SYNC: begin
                    // No timeout while waiting for the window.
                    if (window_open) begin
                        c_valid_reg <= 1'b1;
                        count_reg   <= '0;
                        state_reg   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // Once started, the write finishes even if the window closes.
                    if (C_Rdy) begin
                        c_valid_reg    <= 1'b0;
                        last_grant_reg <= grant_id_reg;
                        state_reg      <= ST_IDLE;
                    end else if (count_reg == COUNT_LAST) begin
                        c_valid_reg     <= 1'b0;
                        timeout_err_reg <= 1'b1;
                        last_grant_reg  <= grant_id_reg;
                        state_reg       <= ST_IDLE;
                    end else begin
                        count_reg <= count_reg + 1'b1;
                    end
                end
                default: begin
                    c_valid_reg <= 1'b0;
                    state_reg   <= ST_IDLE;
                end
            endcase
        end
    end

    assign C_Addr      = c_addr_reg;
    assign C_Data      = c_data_reg;
    assign C_Valid     = c_valid_reg;
    assign Grant_Id    = grant_id_reg;
    assign Busy        = (state_reg != ST_IDLE);
    assign Timeout_Err = timeout_err_reg;

endmodule

// File: tb/tb_color_config_arbiter.sv
// -----------------------------------------------------------------------------
// tb_color_config_arbiter
//
// Self-checking bench for color_config_arbiter (FRAME_SYNC=1, VSYNC_POL=1,
// TIMEOUT_CYCLES=8). Holding VSync high gives the immediate-issue behaviour.
// The reference model tracks only the last-granted requester and derives each
// write's expected grant, C-port values, duration and timeout from the rules.
// -----------------------------------------------------------------------------
module tb_color_config_arbiter;

    localparam int TO = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0_valid, req1_valid;
    logic [1:0] req0_addr, req1_addr;
    logic [7:0] req0_data, req1_data;
    logic       req0_rdy, req1_rdy;
    logic       vsync;
    logic [1:0] c_addr;
    logic [7:0] c_data;
    logic       c_valid;
    logic       c_rdy;
    logic       grant_id;
    logic       busy;
    logic       timeout_err;

    int errors = 0;
    int checks = 0;
    bit m_last = 1'b1;   // model: requester granted last (reset makes 0 win a tie)

    always #2 clk = ~clk;

    color_config_arbiter #(
        .C_ADDR_WIDTH  (2),
        .C_DATA_WIDTH  (8),
        .FRAME_SYNC    (1),
        .VSYNC_POL     (1),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .Clk        (clk),
        .Rst        (rst_n),
        .Req0_Valid (req0_valid),
        .Req0_Addr  (req0_addr),
        .Req0_Data  (req0_data),
        .Req0_Rdy   (req0_rdy),
        .Req1_Valid (req1_valid),
        .Req1_Addr  (req1_addr),
        .Req1_Data  (req1_data),
        .Req1_Rdy   (req1_rdy),
        .VSync      (vsync),
        .C_Addr     (c_addr),
        .C_Data     (c_data),
        .C_Valid    (c_valid),
        .C_Rdy      (c_rdy),
        .Grant_Id   (grant_id),
        .Busy       (busy),
        .Timeout_Err(timeout_err)
    );

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One complete write: offer requests, hold the window closed for vs_delay
    // cycles, then answer C_Rdy in ISSUE cycle rdy_delay (never if >= TO).
    task automatic run_txn(input bit v0, input bit v1,
                           input logic [1:0] a0, input logic [7:0] d0,
                           input logic [1:0] a1, input logic [7:0] d1,
                           input int vs_delay, input int rdy_delay,
                           input string tag);
        bit         exp_sel;
        bit         exp_to;
        int         n_issue;
        logic [1:0] ea;
        logic [7:0] ed;
        int         err0;
        err0    = errors;
        exp_sel = (v0 && v1) ? ~m_last : v1;
        ea      = exp_sel ? a1 : a0;
        ed      = exp_sel ? d1 : d0;
        exp_to  = (rdy_delay >= TO);
        n_issue = exp_to ? TO : rdy_delay + 1;

        req0_valid = v0; req0_addr = a0; req0_data = d0;
        req1_valid = v1; req1_addr = a1; req1_data = d1;
        vsync = (vs_delay == 0);
        c_rdy = 1'b0;
        #1;
        checks++;
        if (req0_rdy !== (exp_sel == 1'b0) || req1_rdy !== (exp_sel == 1'b1) || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s idle_rdy: rdy0=%b rdy1=%b busy=%b, required rdy0=%b rdy1=%b busy=0",
                     tag, req0_rdy, req1_rdy, busy, !exp_sel, exp_sel);
        end

        step();  // transfer edge
        checks++;
        if (busy !== 1'b1 || grant_id !== exp_sel || c_valid !== 1'b0 || req0_rdy !== 1'b0 || req1_rdy !== 1'b0) begin
            errors++;
            $display("FAIL %s accept: busy=%b grant=%b c_valid=%b rdy=%b%b, required busy=1 grant=%b c_valid=0 rdy=00",
                     tag, busy, grant_id, c_valid, req1_rdy, req0_rdy, exp_sel);
        end

        for (int k = 0; k < vs_delay; k++) begin
            step();
            checks++;
            if (c_valid !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL %s wait_sync[%0d]: c_valid=%b busy=%b, required c_valid=0 busy=1",
                         tag, k, c_valid, busy);
            end
        end
        vsync = 1'b1;

        step();  // first ISSUE cycle
        for (int i = 0; i < n_issue; i++) begin
            checks++;
            if (c_valid !== 1'b1 || c_addr !== ea || c_data !== ed || busy !== 1'b1 ||
                req0_rdy !== 1'b0 || req1_rdy !== 1'b0) begin
                errors++;
                $display("FAIL %s issue[%0d]: c_valid=%b addr=%h data=%h busy=%b rdy=%b%b, required 1 %h %h 1 00",
                         tag, i, c_valid, c_addr, c_data, busy, req1_rdy, req0_rdy, ea, ed);
            end
            c_rdy = (i == rdy_delay);
            vsync = 1'($urandom_range(0, 1));  // window may close mid-write
            step();
        end
        c_rdy = 1'b0;

        checks++;
        if (c_valid !== 1'b0 || busy !== 1'b0 || timeout_err !== exp_to || grant_id !== exp_sel) begin
            errors++;
            $display("FAIL %s done: c_valid=%b busy=%b timeout=%b grant=%b, required 0 0 %b %b",
                     tag, c_valid, busy, timeout_err, grant_id, exp_to, exp_sel);
        end
        m_last = exp_sel;

        req0_valid = 1'b0;
        req1_valid = 1'b0;
        vsync = 1'b0;
        step();
        checks++;
        if (timeout_err !== 1'b0 || c_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s after: timeout=%b c_valid=%b busy=%b, required 0 0 0",
                     tag, timeout_err, c_valid, busy);
        end
        $display("txn %s: v=%b%b grant=%0d addr=%h data=%h vs_delay=%0d rdy_delay=%0d timeout=%b %s",
                 tag, v1, v0, exp_sel, ea, ed, vs_delay, rdy_delay, exp_to,
                 (errors == err0) ? "ok" : "bad");
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_addr = '0; req1_addr = '0; req0_data = '0; req1_data = '0;
        vsync = 1'b0; c_rdy = 1'b0;
        step();
        step();
        checks++;
        if (c_addr !== 2'd0 || c_data !== 8'd0 || c_valid !== 1'b0 || grant_id !== 1'b0 ||
            busy !== 1'b0 || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: addr=%h data=%h valid=%b grant=%b busy=%b to=%b, required all 0",
                     c_addr, c_data, c_valid, grant_id, busy, timeout_err);
        end
        rst_n = 1'b1;
        m_last = 1'b1;
        step();
        $display("txn reset: outputs cleared");
    endtask

    task automatic test_single();
        run_txn(1'b1, 1'b0, 2'b01, 8'h5A, 2'b00, 8'h00, 0, 0, "single");
    endtask

    task automatic test_tie();
        for (int n = 0; n < 4; n++)
            run_txn(1'b1, 1'b1, 2'(n), 8'(8'h10 + n), 2'(3 - n), 8'(8'hA0 + n), 0, 0, "tie");
    endtask

    task automatic test_frame_gating();
        run_txn(1'b0, 1'b1, 2'b00, 8'h00, 2'd3, 8'hF0, 5, 0, "frame_gate");
    endtask

    task automatic test_timeout();
        run_txn(1'b1, 1'b0, 2'd2, 8'h33, 2'd0, 8'h00, 0, 20, "timeout");
        run_txn(1'b0, 1'b1, 2'd0, 8'h00, 2'd1, 8'hC3, 0, 1, "post_timeout");
    endtask

    task automatic test_backpressure();
        run_txn(1'b1, 1'b0, 2'd3, 8'h96, 2'd0, 8'h00, 1, 3, "backpressure");
    endtask

    task automatic test_reset_mid_issue();
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_addr = 2'd2; req1_data = 8'h77;
        vsync = 1'b1; c_rdy = 1'b0;
        step();
        req1_valid = 1'b0;
        step();
        checks++;
        if (c_valid !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_issue_pre: c_valid=%b, required 1", c_valid);
        end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        checks++;
        if (c_addr !== 2'd0 || c_data !== 8'd0 || c_valid !== 1'b0 || grant_id !== 1'b0 ||
            busy !== 1'b0 || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_issue: addr=%h data=%h valid=%b grant=%b busy=%b to=%b, required all 0",
                     c_addr, c_data, c_valid, grant_id, busy, timeout_err);
        end
        m_last = 1'b1;
        $display("txn reset_mid_issue: outputs cleared");
        run_txn(1'b1, 1'b1, 2'd1, 8'h11, 2'd2, 8'h22, 0, 0, "tie_after_reset");
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            bit v0, v1;
            int pat;
            pat = $urandom_range(1, 3);
            v0 = pat[0];
            v1 = pat[1];
            run_txn(v0, v1, 2'($urandom), 8'($urandom), 2'($urandom), 8'($urandom),
                    $urandom_range(0, 3), $urandom_range(0, 10), "random");
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_tie();
        test_frame_gating();
        test_timeout();
        test_backpressure();
        test_reset_mid_issue();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
